// File: rtl/hex_scan_ctrl_pkg.sv
// Shared display definitions for the multiplexed 7-segment scan controller.
package hex_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

endpackage

// File: rtl/hex_scan_ctrl_hex_to_seg.sv
// Hex nibble to abcdefg segment pattern (active-high, bit 6 = a, bit 0 = g).
module hex_to_seg
    import hex_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// 4-digit 7-segment scan controller: handshaked 16-bit value, frame-aligned
// commit, per-slot dead time, all pin outputs registered.
module hex_scan_ctrl
    import hex_scan_ctrl_pkg::*;
#(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           data,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [NUM_DIGITS-1:0] anodes,
    output logic [6:0]            segments,
    output logic                  frame_start
);

    localparam int CNT_W = $clog2(DIGIT_TICKS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] ON_FIRST   = CNT_W'(BLANK_TICKS);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_TICKS - 1);

    slot_state_t           state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [1:0]            dig, dig_next;
    logic [15:0]           disp, shadow;
    logic                  pending;
    logic                  frame_edge, commit, accept;
    logic [15:0]           view;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] onehot;
    logic [6:0]            seg_dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            dig   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            dig   <= dig_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        dig_next   = dig;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) state_next = ON;
            end
            ON: begin
                if (cnt == SLOT_LAST) begin
                    cnt_next   = '0;
                    dig_next   = dig + 2'd1;
                    state_next = BLANK;
                end
            end
            default: state_next = BLANK;
        endcase
    end

    // Output registers lag the slot state by one edge, so the commit edge is
    // the same edge that turns digit 0 on; bypass the shadow onto that edge.
    assign frame_edge = (state == ON) && (dig == 2'd0) && (cnt == ON_FIRST);
    assign commit     = frame_edge && pending;
    assign accept     = data_valid && data_ready && !pending;
    assign view       = commit ? shadow : disp;
    assign nibble     = view[{dig, 2'b00} +: 4];
    assign onehot     = NUM_DIGITS'(1) << dig;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp    <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (commit) begin
            disp    <= shadow;
            pending <= 1'b0;
        end else if (accept) begin
            shadow  <= data;
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anodes      <= '1;
            segments    <= SEG_OFF;
            frame_start <= 1'b0;
            data_ready  <= 1'b1;
        end else begin
            data_ready  <= !pending;
            frame_start <= frame_edge;
            if (state == ON) begin
                anodes   <= digit_en[dig] ? ~onehot : '1;
                segments <= seg_dec;
            end else begin
                anodes   <= '1;
                segments <= SEG_OFF;
            end
        end
    end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Scan controller for the 4-digit multiplexed 7-segment display. It accepts a 16-bit value through a valid/ready handshake and holds it in a shadow register. It commits that value to the display only at a frame boundary, so a frame never shows a mix of old and new digits. It then time-multiplexes the four digits with a programmable slot length and an anti-ghosting dead time between slots. It sits between any producer of a 16-bit hex value and the board's anode/segment pins.

## Interface

- DIGIT_TICKS, 50000: clk cycles per digit slot (blank + on); frame = 4*DIGIT_TICKS.
- BLANK_TICKS, 500: dead-time cycles at start of each slot with all anodes off; 1 <= BLANK_TICKS < DIGIT_TICKS.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- data  in  16  hex value; nibble k drives digit k (digit 0 = data[3:0], rightmost).
- data_valid  in  1  producer has a value on data.
- data_ready  out  1  shadow register free; transfer on data_valid && data_ready at posedge.
- digit_en  in  4  per-digit enable; disabled digit keeps its slot timing but its anode stays off.
- anodes  out  4  digit select, active-low, anodes[k] = digit k.
- segments  out  7  abcdefg, active-high; all zero while blanking.
- frame_start  out  1  one-cycle pulse on the cycle digit 0 turns on, after any commit.

## Operation

- FSM states: BLANK, ON; digit index dig (2 bits); slot counter cnt (width clog2(DIGIT_TICKS)).
- BLANK: cnt counts 0..BLANK_TICKS-1; anodes = 4'b1111, segments = 0. At cnt == BLANK_TICKS-1, go to ON.
- ON: cnt continues BLANK_TICKS..DIGIT_TICKS-1.
  - anodes[dig] = 0 if digit_en[dig], all others 1.
  - segments = decode(disp[4*dig+:4]).
  - At cnt == DIGIT_TICKS-1: cnt <= 0, dig <= dig+1 (3 wraps to 0), go to BLANK.
- Handshake: pending flag; data_ready = !pending (registered state).
  - Accept: shadow <= data, pending <= 1.
  - While pending, further data_valid is ignored; the shadow is never overwritten.
- Commit: on the BLANK->ON transition with dig == 0 and pending = 1, disp <= shadow and pending <= 0.
  - Digit 0 segments on that same edge already reflect the new value.
  - data_ready rises on the following cycle.
- A transfer arriving mid-frame waits for the next frame boundary; at most one frame plus one slot of latency.
- digit_en is sampled every cycle; a change takes effect on the next edge.
- Reset (any state, mid-slot included): state BLANK, cnt 0, dig 0, disp 0, shadow 0, pending 0.
  - Outputs: anodes 4'b1111, segments 0, frame_start 0, data_ready 1.

## Timing

- All outputs are registered; no combinational path from inputs to pins.
- Cycle 0 = first edge after rst_n deasserts.
  - Digit 0 anode low during cycles BLANK_TICKS..DIGIT_TICKS-1.
  - Digit k on during k*DIGIT_TICKS + [BLANK_TICKS, DIGIT_TICKS-1].
- On time per slot = DIGIT_TICKS-BLANK_TICKS. No cycle ever has two anodes low.
- frame_start is high in cycles n*4*DIGIT_TICKS + BLANK_TICKS.
- data_ready falls the cycle after acceptance. It rises the cycle after commit.

## Structure

- Shared display package:
  - NUM_DIGITS = 4.
  - Slot state enum (BLANK, ON).
  - Segment encoding constant SEG_OFF = 7'b0000000.
- One sub-module: hex_to_seg, the existing combinational hex-to-abcdefg decoder, fed by the selected nibble. Its output is registered in this block.

## Test plan

All scenarios use DIGIT_TICKS=8, BLANK_TICKS=2.

- Reset release -> cycles 0-1: anodes 1111, segments 0000000, data_ready 1. Cycles 2-7: anodes 1110, segments 1111110 ("0"). frame_start high only in cycles 2, 34, 66.
- Send 16'h1234 in cycle 3 -> data_ready 0 from cycle 4. Digits still show 0 through cycle 31. Cycle 34: anodes 1110, segments = decode(4). data_ready 1 from cycle 35. Digit 3 (cycles 58-63) = decode(1).
- Send 16'hAAAA, then hold data_valid=1 with 16'h5555 while pending -> next frame displays AAAA, not 5555. 5555 is accepted only after data_ready rises.
- digit_en = 4'b0101 over two frames -> anodes only ever 1111, 1110, 1011. Slot timing is unchanged.
- Assert rst_n=0 for one cycle during digit 2 ON after 16'hF0F0 committed -> next cycle: anodes 1111, segments 0, data_ready 1. The restart shows 0000, not F0F0.
- Commit 16'hF0F0 -> digit 0 segments 1111110, digit 1 segments 1000111. Check every cycle that no two anodes are low simultaneously.
